// File: rtl/lc4_regfile_ss.sv
// ----------------------------------------------------------------------------
// lc4_regfile_ss
//
// Purpose:
//   Two-issue register file for the superscalar LC4 pipeline. It has four
//   combinational read ports, two write (writeback) ports and a per-register
//   busy scoreboard that decode uses to detect hazards.
//
// Optional build macro:
//   LC4_REGFILE_BYPASS_EN - when defined, a read whose selector matches an
//   active write port returns that port's write data in the same cycle, if
//   gwe=1. Slot B wins when both ports match. When the macro is undefined,
//   reads return stored contents only.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   gwe                global write enable; gates all state updates
//   i_rs_a / i_rt_a    slot A read selectors  -> o_rs_a_data / o_rt_a_data
//   i_rs_b / i_rt_b    slot B read selectors  -> o_rs_b_data / o_rt_b_data
//   i_rd_a, i_wdata_a, i_rd_we_a   writeback slot A (older)
//   i_rd_b, i_wdata_b, i_rd_we_b   writeback slot B (younger)
//   i_iss_rd_a, i_iss_we_a         issue slot A destination
//   i_iss_rd_b, i_iss_we_b         issue slot B destination
//   o_busy             bit r is set while register r has a write in flight
// ----------------------------------------------------------------------------
module lc4_regfile_ss #(
    parameter int n  = 16,
    parameter int AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gwe,
    input  logic [AW-1:0]     i_rs_a,
    output logic [n-1:0]      o_rs_a_data,
    input  logic [AW-1:0]     i_rt_a,
    output logic [n-1:0]      o_rt_a_data,
    input  logic [AW-1:0]     i_rs_b,
    output logic [n-1:0]      o_rs_b_data,
    input  logic [AW-1:0]     i_rt_b,
    output logic [n-1:0]      o_rt_b_data,
    input  logic [AW-1:0]     i_rd_a,
    input  logic [n-1:0]      i_wdata_a,
    input  logic              i_rd_we_a,
    input  logic [AW-1:0]     i_rd_b,
    input  logic [n-1:0]      i_wdata_b,
    input  logic              i_rd_we_b,
    input  logic [AW-1:0]     i_iss_rd_a,
    input  logic              i_iss_we_a,
    input  logic [AW-1:0]     i_iss_rd_b,
    input  logic              i_iss_we_b,
    output logic [2**AW-1:0]  o_busy
);

    localparam int NREG = 2**AW;
    localparam int NRD  = 4;

    logic [n-1:0]      regs_reg [NREG];
    logic [NREG-1:0]   busy_reg;

    // Read selectors and results gathered into arrays so one generate loop
    // builds every read port identically.
    logic [AW-1:0]     rd_sel  [NRD];
    logic [n-1:0]      rd_data [NRD];

    assign rd_sel[0] = i_rs_a;
    assign rd_sel[1] = i_rt_a;
    assign rd_sel[2] = i_rs_b;
    assign rd_sel[3] = i_rt_b;

    assign o_rs_a_data = rd_data[0];
    assign o_rt_a_data = rd_data[1];
    assign o_rs_b_data = rd_data[2];
    assign o_rt_b_data = rd_data[3];

    assign o_busy = busy_reg;

    genvar gi;

    // Register storage and scoreboard, one slice per register.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [AW-1:0] IDX = gi[AW-1:0];

            logic wr_a_hit;
            logic wr_b_hit;
            logic set_hit;
            logic clr_hit;

            assign wr_a_hit = i_rd_we_a && (i_rd_a == IDX);
            assign wr_b_hit = i_rd_we_b && (i_rd_b == IDX);
            assign set_hit  = (i_iss_we_a && (i_iss_rd_a == IDX)) ||
                              (i_iss_we_b && (i_iss_rd_b == IDX));
            assign clr_hit  = wr_a_hit || wr_b_hit;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs_reg[gi] <= '0;
                end else if (gwe) begin
                    // Slot B is the younger instruction, so it wins a conflict.
                    if (wr_b_hit) begin
                        regs_reg[gi] <= i_wdata_b;
                    end else if (wr_a_hit) begin
                        regs_reg[gi] <= i_wdata_a;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    busy_reg[gi] <= 1'b0;
                end else if (gwe) begin
                    // A new issue is younger than a retiring write, so set
                    // takes priority over clear.
                    if (set_hit) begin
                        busy_reg[gi] <= 1'b1;
                    end else if (clr_hit) begin
                        busy_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Read ports.
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = regs_reg[rd_sel[gi]];
`ifdef LC4_REGFILE_BYPASS_EN
                // Check A first so that B overrides it when both match.
                if (gwe && i_rd_we_a && (i_rd_a == rd_sel[gi])) begin
                    rd_data[gi] = i_wdata_a;
                end
                if (gwe && i_rd_we_b && (i_rd_b == rd_sel[gi])) begin
                    rd_data[gi] = i_wdata_b;
                end
`endif
            end
        end
    endgenerate

endmodule
